// File: rtl/core_boot_controller.sv
// Run controller for one RISC-V core and its shared BRAM: loads a program image through
// port A, holds the core in reset, then supervises the run until a done write or timeout.
module core_boot_controller #(
    parameter int unsigned                   ADDR_WIDTH      = 10,
    parameter int unsigned                   DATA_WIDTH      = 32,
    parameter int unsigned                   CORE_ADDR_WIDTH = 14,
    parameter logic [CORE_ADDR_WIDTH-1:0]    DONE_ADDR       = 14'h3FF,
    parameter logic [DATA_WIDTH-1:0]         PASS_VALUE      = 32'h1,
    parameter int unsigned                   RST_HOLD_CYCLES = 6,
    parameter int unsigned                   TIMEOUT_CYCLES  = 1000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic                       i_load_valid,
    output logic                       o_load_ready,
    input  logic [DATA_WIDTH-1:0]      i_load_data,
    input  logic                       i_load_last,
    output logic                       o_core_reset,
    input  logic [CORE_ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0]      i_core_wr_data,
    input  logic [3:0]                 i_core_wr_en,
    output logic [ADDR_WIDTH-1:0]      o_bram_addr,
    output logic [DATA_WIDTH-1:0]      o_bram_wr_data,
    output logic [3:0]                 o_bram_wr_en,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_pass,
    output logic                       o_timeout,
    output logic                       o_load_trunc,
    output logic [31:0]                o_cycle_count,
    output logic [DATA_WIDTH-1:0]      o_result
);

    localparam int unsigned HOLD_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam int unsigned CNT_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RST_HOLD,
        ST_RUN,
        ST_DONE,
        ST_TIMEOUT
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [ADDR_WIDTH-1:0]   ld_addr_q, ld_addr_d;
    logic [DATA_WIDTH-1:0]   ld_data_q, ld_data_d;
    logic [3:0]              ld_we_q, ld_we_d;
    logic                    ready_q, ready_d;
    logic                    core_rst_q, core_rst_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    pass_q, pass_d;
    logic                    timeout_q, timeout_d;
    logic                    trunc_q, trunc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    done_evt;

    assign done_evt = (i_core_addr == DONE_ADDR) && (|i_core_wr_en);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_q     <= '0;
            ld_addr_q  <= '0;
            ld_data_q  <= '0;
            ld_we_q    <= '0;
            ready_q    <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            trunc_q    <= 1'b0;
            count_q    <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            ld_addr_q  <= ld_addr_d;
            ld_data_q  <= ld_data_d;
            ld_we_q    <= ld_we_d;
            ready_q    <= ready_d;
            core_rst_q <= core_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            trunc_q    <= trunc_d;
            count_q    <= count_d;
            result_q   <= result_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        ld_addr_d = ld_addr_q;
        ld_data_d = ld_data_q;
        ld_we_d   = '0;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        trunc_d   = trunc_q;
        count_d   = count_q;
        result_d  = result_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_TIMEOUT: begin
                if (i_start) begin
                    state_d   = ST_LOAD;
                    ptr_d     = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                    trunc_d   = 1'b0;
                    count_d   = '0;
                    result_d  = '0;
                end
            end
            ST_LOAD: begin
                if (i_load_valid) begin
                    ld_addr_d = ptr_q;
                    ld_data_d = i_load_data;
                    ld_we_d   = 4'hF;
                    hold_d    = '0;
                    // The pointer saturates at the last word so a truncated image never wraps.
                    if (ptr_q != '1) begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                    if (i_load_last) begin
                        state_d = ST_RST_HOLD;
                    end else if (ptr_q == '1) begin
                        state_d = ST_RST_HOLD;
                        trunc_d = 1'b1;
                    end
                end
            end
            ST_RST_HOLD: begin
                if (hold_q == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_RUN: begin
                if (count_q != '1) begin
                    count_d = count_q + CNT_W'(1);
                end
                // A done write in the final timeout cycle still counts as completion.
                if (done_evt) begin
                    state_d  = ST_DONE;
                    result_d = i_core_wr_data;
                    pass_d   = (i_core_wr_data == PASS_VALUE);
                end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ST_TIMEOUT;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ready_d    = (state_d == ST_LOAD);
        core_rst_d = (state_d != ST_RUN);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_RST_HOLD) || (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE) || (state_d == ST_TIMEOUT);
    end

    // Core accesses bypass the load registers so RUN adds no latency on port A.
    always_comb begin
        o_bram_addr    = ld_addr_q;
        o_bram_wr_data = ld_data_q;
        o_bram_wr_en   = ld_we_q;
        if (state_q == ST_RUN) begin
            o_bram_addr    = i_core_addr[ADDR_WIDTH-1:0];
            o_bram_wr_data = i_core_wr_data;
            o_bram_wr_en   = i_core_wr_en;
        end
    end

    assign o_load_ready  = ready_q;
    assign o_core_reset  = core_rst_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_pass        = pass_q;
    assign o_timeout     = timeout_q;
    assign o_load_trunc  = trunc_q;
    assign o_cycle_count = count_q;
    assign o_result      = result_q;

endmodule

// File: tb/tb_core_boot_controller.sv
// Bench for core_boot_controller: randomized loads and runs checked against a
// transaction-level model of load writes, reset hold, completion and timeout.
module tb_core_boot_controller;

    localparam int unsigned AW    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned CAW   = 14;
    localparam int unsigned HOLD  = 6;
    localparam int unsigned TMO   = 64;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [CAW-1:0] DONE_A = 14'h3FF;
    localparam logic [DW-1:0]  PASS_V = 32'h1;

    logic           clk = 1'b0;
    logic           reset;
    logic           i_start;
    logic           i_load_valid;
    logic           o_load_ready;
    logic [DW-1:0]  i_load_data;
    logic           i_load_last;
    logic           o_core_reset;
    logic [CAW-1:0] i_core_addr;
    logic [DW-1:0]  i_core_wr_data;
    logic [3:0]     i_core_wr_en;
    logic [AW-1:0]  o_bram_addr;
    logic [DW-1:0]  o_bram_wr_data;
    logic [3:0]     o_bram_wr_en;
    logic           o_busy;
    logic           o_done;
    logic           o_pass;
    logic           o_timeout;
    logic           o_load_trunc;
    logic [31:0]    o_cycle_count;
    logic [DW-1:0]  o_result;

    int checks = 0;
    int failures = 0;

    core_boot_controller #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CORE_ADDR_WIDTH(CAW), .DONE_ADDR(DONE_A),
        .PASS_VALUE(PASS_V), .RST_HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_load_valid(i_load_valid), .o_load_ready(o_load_ready),
        .i_load_data(i_load_data), .i_load_last(i_load_last),
        .o_core_reset(o_core_reset), .i_core_addr(i_core_addr),
        .i_core_wr_data(i_core_wr_data), .i_core_wr_en(i_core_wr_en),
        .o_bram_addr(o_bram_addr), .o_bram_wr_data(o_bram_wr_data),
        .o_bram_wr_en(o_bram_wr_en), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_timeout(o_timeout), .o_load_trunc(o_load_trunc),
        .o_cycle_count(o_cycle_count), .o_result(o_result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_core_reset"}, 64'(o_core_reset), 64'd1);
        chk({tag, "_ready"}, 64'(o_load_ready), 64'd0);
        chk({tag, "_wr_en"}, 64'(o_bram_wr_en), 64'd0);
        chk({tag, "_addr"}, 64'(o_bram_addr), 64'd0);
        chk({tag, "_wr_data"}, 64'(o_bram_wr_data), 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_pass"}, 64'(o_pass), 64'd0);
        chk({tag, "_timeout"}, 64'(o_timeout), 64'd0);
        chk({tag, "_trunc"}, 64'(o_load_trunc), 64'd0);
        chk({tag, "_count"}, 64'(o_cycle_count), 64'd0);
        chk({tag, "_result"}, 64'(o_result), 64'd0);
    endtask

    task automatic do_start();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_ready", 64'(o_load_ready), 64'd1);
        chk("start_busy", 64'(o_busy), 64'd1);
        chk("start_done", 64'(o_done), 64'd0);
        chk("start_pass", 64'(o_pass), 64'd0);
        chk("start_timeout", 64'(o_timeout), 64'd0);
        chk("start_trunc", 64'(o_load_trunc), 64'd0);
        chk("start_count", 64'(o_cycle_count), 64'd0);
        chk("start_result", 64'(o_result), 64'd0);
        chk("start_core_reset", 64'(o_core_reset), 64'd1);
    endtask

    // Streams an image of n words; the model expects word k at address k, one cycle late,
    // stopping at depth with truncation when the last flag has not been seen.
    task automatic do_load(input int n, input bit use_last, input bit stall, input bit rnd_data);
        int       acc = 0;
        int       cyc = 0;
        bit       fin = 0;
        bit       hs;
        bit       last_acc = 0;
        logic [DW-1:0] d;
        while (!fin) begin
            i_load_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            d = rnd_data ? DW'($urandom) : DW'(32'hA0 + acc);
            i_load_data = d;
            i_load_last = use_last && (acc == n - 1);
            i_start = ($urandom_range(0, 7) == 0);
            chk("load_ready", 64'(o_load_ready), 64'd1);
            hs = i_load_valid;
            tick();
            if (hs) begin
                chk("load_wr_en", 64'(o_bram_wr_en), 64'hF);
                chk("load_addr", 64'(o_bram_addr), 64'(acc));
                chk("load_data", 64'(o_bram_wr_data), 64'(d));
                last_acc = i_load_last;
                acc++;
                fin = last_acc || (acc == DEPTH);
            end else begin
                chk("load_stall_wr_en", 64'(o_bram_wr_en), 64'd0);
            end
            cyc++;
            if (!fin && cyc > 400) begin
                chk("load_budget", 64'd1, 64'd0);
                fin = 1;
            end
        end
        i_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_last = 1'b0;
        chk("hold_ready", 64'(o_load_ready), 64'd0);
        chk("hold_trunc", 64'(o_load_trunc), 64'(!last_acc));
        chk("hold_busy", 64'(o_busy), 64'd1);
        chk("hold_core_reset", 64'(o_core_reset), 64'd1);
        for (int h = 2; h <= int'(HOLD); h++) begin
            tick();
            chk("hold_core_reset", 64'(o_core_reset), 64'd1);
            chk("hold_wr_en", 64'(o_bram_wr_en), 64'd0);
        end
        tick();
        chk("run_core_reset", 64'(o_core_reset), 64'd0);
        chk("run_busy", 64'(o_busy), 64'd1);
    endtask

    // done_at < 0 means the core never writes the done address.
    task automatic do_run(input int done_at, input logic [DW-1:0] val);
        int  k = 0;
        bit  fin = 0;
        bit  hit = 0;
        logic [CAW-1:0] a;
        logic [3:0]     we;
        logic [DW-1:0]  wd;
        while (!fin) begin
            hit = (k == done_at);
            a = CAW'($urandom);
            we = 4'($urandom);
            if (hit) begin
                a = DONE_A;
                if (we == 4'h0) we = 4'h1;
                wd = val;
            end else begin
                if (a == DONE_A) a = a ^ CAW'(1);
                wd = DW'($urandom);
            end
            i_core_addr = a;
            i_core_wr_en = we;
            i_core_wr_data = wd;
            i_start = ($urandom_range(0, 7) == 0);
            #1;
            chk("run_addr", 64'(o_bram_addr), 64'(a[AW-1:0]));
            chk("run_wr_data", 64'(o_bram_wr_data), 64'(wd));
            chk("run_wr_en", 64'(o_bram_wr_en), 64'(we));
            chk("run_core_reset", 64'(o_core_reset), 64'd0);
            chk("run_count", 64'(o_cycle_count), 64'(k));
            chk("run_done", 64'(o_done), 64'd0);
            fin = hit || (k == int'(TMO) - 1);
            tick();
            k++;
        end
        i_start = 1'b0;
        chk("end_wr_en", 64'(o_bram_wr_en), 64'd0);
        chk("end_done", 64'(o_done), 64'd1);
        chk("end_pass", 64'(o_pass), 64'(hit && (val == PASS_V)));
        chk("end_timeout", 64'(o_timeout), 64'(!hit));
        chk("end_result", 64'(o_result), hit ? 64'(val) : 64'd0);
        chk("end_count", 64'(o_cycle_count), 64'(k));
        chk("end_core_reset", 64'(o_core_reset), 64'd1);
        chk("end_busy", 64'(o_busy), 64'd0);
        i_core_wr_en = 4'h0;
        tick();
        chk("end_hold_count", 64'(o_cycle_count), 64'(k));
        chk("end_hold_done", 64'(o_done), 64'd1);
    endtask

    initial begin
        int n;
        bit ul;
        int da;
        reset = 1'b1;
        i_start = 1'b0;
        i_load_valid = 1'b0;
        i_load_data = '0;
        i_load_last = 1'b0;
        i_core_addr = '0;
        i_core_wr_data = '0;
        i_core_wr_en = '0;
        tick();
        tick();
        chk_idle("reset");
        reset = 1'b0;
        tick();
        chk_idle("idle");

        // Directed image A0..A3, then a passing completion after 50 run cycles.
        do_start();
        do_load(4, 1'b1, 1'b0, 1'b0);
        do_run(50, 32'h1);

        // Failing completion value, then restart clears the flags.
        do_start();
        do_load(int'($urandom_range(1, DEPTH)), 1'b1, 1'b1, 1'b1);
        do_run(50, 32'h2);

        // Timeout with no done write, then done write in the final cycle.
        do_start();
        do_load(3, 1'b1, 1'b1, 1'b1);
        do_run(-1, 32'h0);
        do_start();
        do_load(2, 1'b1, 1'b0, 1'b1);
        do_run(int'(TMO) - 1, 32'h1);

        // Truncated image (10 words, no last) and an image that exactly fills depth.
        do_start();
        do_load(10, 1'b0, 1'b1, 1'b1);
        do_run(int'($urandom_range(0, 20)), 32'h1);
        do_start();
        do_load(int'(DEPTH), 1'b1, 1'b1, 1'b1);
        do_run(5, 32'h7);

        for (int it = 0; it < 4; it++) begin
            n = int'($urandom_range(1, 10));
            ul = (n < int'(DEPTH)) ? 1'b1 : 1'(($urandom_range(0, 1)));
            da = int'($urandom_range(0, TMO + 8)) - 1;
            if (da >= int'(TMO)) da = -1;
            do_start();
            do_load(n, ul, 1'b1, 1'b1);
            do_run(da, ($urandom_range(0, 1) != 0) ? PASS_V : DW'($urandom));
        end

        // Reset during RUN aborts at once.
        do_start();
        do_load(3, 1'b1, 1'b0, 1'b1);
        i_core_addr = 14'h5;
        i_core_wr_en = 4'hF;
        i_core_wr_data = DW'($urandom);
        #1;
        chk("pre_reset_run_wr_en", 64'(o_bram_wr_en), 64'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("run_reset_core_reset", 64'(o_core_reset), 64'd1);
        chk("run_reset_wr_en", 64'(o_bram_wr_en), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk_idle("post_run_reset");
        i_core_wr_en = 4'h0;

        // Reset during LOAD while a write is on port A.
        do_start();
        i_load_valid = 1'b1;
        i_load_data = DW'($urandom);
        i_load_last = 1'b0;
        tick();
        chk("pre_reset_load_wr_en", 64'(o_bram_wr_en), 64'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("load_reset_wr_en", 64'(o_bram_wr_en), 64'd0);
        chk("load_reset_core_reset", 64'(o_core_reset), 64'd1);
        chk("load_reset_ready", 64'(o_load_ready), 64'd0);
        i_load_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_idle("post_load_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_boot_controller.md
Name: core_boot_controller

Overview:
- Run controller for a single RISC-V core and its shared instruction/data BRAM.
- Sequences a test run: streams a program image into BRAM data port A, holds the core in reset for a fixed number of cycles, then releases it.
- While the core runs, owns the port-A mux, counts cycles, detects the core's completion write and applies a timeout.
- Sits between the clock/reset infrastructure and the RISC-V core/BRAM pair, replacing the free-running reset delay chain and the "any write" done flag.

Parameters:
- ADDR_WIDTH, 10, BRAM word-address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, BRAM/core data width.
- CORE_ADDR_WIDTH, 14, width of the core data address.
- DONE_ADDR, 14'h3FF, core word address whose write signals end of test.
- PASS_VALUE, 32'h1, value written to DONE_ADDR that means pass.
- RST_HOLD_CYCLES, 6, cycles the core reset is held after loading (at least 1).
- TIMEOUT_CYCLES, 1000000, run-cycle limit before TIMEOUT.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- i_start  in  1  start pulse; accepted only in IDLE, DONE or TIMEOUT.
- i_load_valid  in  1  program word valid.
- o_load_ready  out  1  controller accepts a word.
- i_load_data  in  DATA_WIDTH  program word.
- i_load_last  in  1  final word of the image.
- o_core_reset  out  1  reset to the core.
- i_core_addr  in  CORE_ADDR_WIDTH  core data address.
- i_core_wr_data  in  DATA_WIDTH  core write data.
- i_core_wr_en  in  4  core byte write enables.
- o_bram_addr  out  ADDR_WIDTH  port-A address.
- o_bram_wr_data  out  DATA_WIDTH  port-A write data.
- o_bram_wr_en  out  4  port-A byte enables.
- o_busy  out  1  high in LOAD, RST_HOLD and RUN.
- o_done  out  1  run finished (DONE or TIMEOUT).
- o_pass  out  1  DONE with data equal to PASS_VALUE.
- o_timeout  out  1  run ended by timeout.
- o_load_trunc  out  1  image exceeded depth before i_load_last.
- o_cycle_count  out  32  RUN cycles elapsed, saturating.
- o_result  out  DATA_WIDTH  data latched from the DONE_ADDR write.

Behaviour:
- Reset (async assert, removal on clk): state IDLE.
  - o_core_reset=1; o_load_ready=0.
  - o_bram_wr_en=0, o_bram_addr=0, o_bram_wr_data=0.
  - o_busy, o_done, o_pass, o_timeout, o_load_trunc = 0; o_cycle_count=0; o_result=0.
  - Load pointer and hold counter = 0.
- Reset asserted mid-operation aborts the run immediately: o_core_reset goes high and o_bram_wr_en goes low combinationally with reset.
- States: IDLE, LOAD, RST_HOLD, RUN, DONE, TIMEOUT. o_core_reset=0 only in RUN.
- IDLE/DONE/TIMEOUT + i_start -> LOAD.
  - Same edge clears the pointer, o_done, o_pass, o_timeout, o_load_trunc, o_cycle_count and o_result.
- i_start is ignored in LOAD, RST_HOLD and RUN.
- LOAD:
  - o_load_ready=1.
  - On each valid&ready cycle, the next edge registers o_bram_addr=ptr, o_bram_wr_data=i_load_data, o_bram_wr_en=4'hF; ptr increments.
  - BRAM write lands one cycle after the handshake.
  - With no handshake, o_bram_wr_en=0 next cycle.
  - On accepting a word with i_load_last=1 -> RST_HOLD.
  - On accepting the word at ptr=2**ADDR_WIDTH-1 without last -> RST_HOLD and o_load_trunc=1; ptr does not wrap.
- RST_HOLD:
  - o_load_ready=0; o_bram_wr_en=0.
  - Stays exactly RST_HOLD_CYCLES cycles, then -> RUN.
- RUN:
  - o_bram_addr=i_core_addr[ADDR_WIDTH-1:0], o_bram_wr_data=i_core_wr_data, o_bram_wr_en=i_core_wr_en.
  - This path is a combinational mux selected by the state register, adding zero latency to core accesses.
  - o_cycle_count increments every RUN cycle and saturates at 2^32-1.
  - Done event: i_core_addr==DONE_ADDR and i_core_wr_en!=0.
    - The write still passes to BRAM.
    - Next edge: -> DONE, o_result=i_core_wr_data, o_pass=(i_core_wr_data==PASS_VALUE).
    - Full-word compare regardless of byte enables.
  - o_cycle_count==TIMEOUT_CYCLES-1 with no done event -> TIMEOUT, o_timeout=1.
  - If the done event and the timeout happen in the same cycle, the done event wins.
- DONE/TIMEOUT:
  - o_done=1; core held in reset; port A idle.
  - Flags and counters hold until i_start or reset.
- o_busy=1 in LOAD, RST_HOLD and RUN.

Test Plan:
- Reset then i_start; stream 4 words (0xA0..0xA3, last on 4th) -> port-A writes addr 0..3, wr_en=F, each 1 cycle after its handshake; o_core_reset stays 1 for 6 cycles after the LOAD exit, then 0.
- In RUN, core writes 32'h1 to 14'h3FF after 50 cycles -> BRAM receives the write; next cycle state DONE, o_done=1, o_pass=1, o_result=1, o_cycle_count=51, o_core_reset=1.
- Same run writing 32'h2 -> o_done=1, o_pass=0, o_result=2; then i_start -> flags cleared, state LOAD.
- TIMEOUT_CYCLES=20, no done write -> after 20 RUN cycles o_timeout=1, o_done=1, o_pass=0; done write on cycle 20 instead -> DONE wins, o_timeout=0.
- ADDR_WIDTH=3, stream 10 words without last -> 8 writes (addr 0..7), o_load_trunc=1, o_load_ready drops, RST_HOLD entered; i_load_valid stalls mid-load hold ptr with no writes.
- Assert reset during RUN and during LOAD -> o_core_reset=1 and o_bram_wr_en=0 immediately; after release, IDLE with all outputs at reset values; i_start during RUN ignored.
